// File: rtl/irem_video_pkg.sv
// irem_video_pkg: shared raster types and default M92 video timing.
// Contents:
//   hcnt_t / vcnt_t  - horizontal (10-bit) and vertical (9-bit) counter types
//   M92_*            - default timing used by the raster generator and by
//                      the tilemap/sprite engines that consume hcnt/vcnt
package irem_video_pkg;

    typedef logic [9:0] hcnt_t;
    typedef logic [8:0] vcnt_t;

    localparam int M92_CE_DIV       = 5;
    localparam int M92_H_TOTAL      = 512;
    localparam int M92_H_VIS        = 320;
    localparam int M92_H_SYNC_START = 360;
    localparam int M92_H_SYNC_LEN   = 32;
    localparam int M92_V_TOTAL      = 284;
    localparam int M92_V_VIS        = 240;
    localparam int M92_V_SYNC_START = 256;
    localparam int M92_V_SYNC_LEN   = 3;
    localparam int M92_H_IRQ        = 328;

endpackage

// File: rtl/irem_ce_div.sv
// irem_ce_div: divides clk down to a one-clk pixel enable every CE_DIV clocks.
// Ports:
//   clk     in   system/video clock
//   reset_n in   asynchronous active-low reset
//   ce_pix  out  registered pulse, high on the clk where the divider sits at CE_DIV-1
module irem_ce_div
    import irem_video_pkg::*;
#(
    parameter int CE_DIV = M92_CE_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic ce_pix
);

    localparam logic [3:0] LAST = 4'(CE_DIV - 1);

    logic [3:0] div;
    logic [3:0] div_next;

    assign div_next = (div == LAST) ? 4'd0 : div + 4'd1;

    // ce_pix is decoded from div_next so it is high exactly while div==LAST
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            ce_pix <= 1'b0;
        end else begin
            div    <= div_next;
            ce_pix <= (div_next == LAST);
        end
    end

endmodule

// File: rtl/irem_video_timing.sv
// irem_video_timing: raster generator with blanking, sync, vblank and raster-compare interrupts.
// Ports:
//   clk            in   system/video clock
//   reset_n        in   asynchronous active-low reset
//   raster_wr      in   one-clk strobe loading raster_line_in into the pending compare
//   raster_line_in in   requested interrupt line
//   ce_pix         out  pixel enable, one clk every CE_DIV clocks
//   hcnt / vcnt    out  pixel and line counters
//   hb / vb        out  horizontal / vertical blank
//   hs / vs        out  horizontal / vertical sync
//   vblank_irq     out  one-clk pulse entering line V_VIS
//   raster_irq     out  one-clk pulse at hcnt==H_IRQ on the active compare line
//   raster_line    out  compare value currently in effect
module irem_video_timing
    import irem_video_pkg::*;
#(
    parameter int CE_DIV       = M92_CE_DIV,
    parameter int H_TOTAL      = M92_H_TOTAL,
    parameter int H_VIS        = M92_H_VIS,
    parameter int H_SYNC_START = M92_H_SYNC_START,
    parameter int H_SYNC_LEN   = M92_H_SYNC_LEN,
    parameter int V_TOTAL      = M92_V_TOTAL,
    parameter int V_VIS        = M92_V_VIS,
    parameter int V_SYNC_START = M92_V_SYNC_START,
    parameter int V_SYNC_LEN   = M92_V_SYNC_LEN,
    parameter int H_IRQ        = M92_H_IRQ
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        raster_wr,
    input  logic [8:0]  raster_line_in,
    output logic        ce_pix,
    output hcnt_t       hcnt,
    output vcnt_t       vcnt,
    output logic        hb,
    output logic        vb,
    output logic        hs,
    output logic        vs,
    output logic        vblank_irq,
    output logic        raster_irq,
    output vcnt_t       raster_line
);

    if (CE_DIV < 2 || CE_DIV > 16) begin : g_bad_ce_div
        $error("CE_DIV must be in 2..16");
    end
    if (H_TOTAL < 2 || H_TOTAL > 1024 || H_VIS > H_TOTAL || H_IRQ >= H_TOTAL) begin : g_bad_h
        $error("horizontal timing does not fit hcnt");
    end
    if (H_SYNC_START < 1 || H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_bad_hsync
        $error("hsync window must lie inside the line");
    end
    if (V_TOTAL < 2 || V_TOTAL > 512 || V_VIS >= V_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_v
        $error("vertical timing does not fit vcnt");
    end

    localparam hcnt_t H_LAST = hcnt_t'(H_TOTAL - 1);
    localparam vcnt_t V_LAST = vcnt_t'(V_TOTAL - 1);

    logic  ce;
    hcnt_t h_next;
    vcnt_t v_next;
    vcnt_t pending;

    irem_ce_div #(.CE_DIV(CE_DIV)) u_ce_div (
        .clk    (clk),
        .reset_n(reset_n),
        .ce_pix (ce)
    );

    assign ce_pix = ce;

    always_comb begin
        h_next = (hcnt == H_LAST) ? '0 : hcnt + hcnt_t'(1);
        v_next = (hcnt != H_LAST) ? vcnt : (vcnt == V_LAST) ? '0 : vcnt + vcnt_t'(1);
    end

    // Decodes use the next counter values so they line up with hcnt/vcnt.
    // vs is only re-evaluated at the hsync start pixel so both sync edges coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            hb          <= 1'b0;
            vb          <= 1'b0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            vblank_irq  <= 1'b0;
            raster_irq  <= 1'b0;
            pending     <= 9'h1FF;
            raster_line <= 9'h1FF;
        end else begin
            vblank_irq <= 1'b0;
            raster_irq <= 1'b0;
            if (raster_wr)
                pending <= raster_line_in;
            if (ce) begin
                hcnt       <= h_next;
                vcnt       <= v_next;
                hb         <= int'(h_next) >= H_VIS;
                vb         <= int'(v_next) >= V_VIS;
                hs         <= int'(h_next) >= H_SYNC_START && int'(h_next) < H_SYNC_START + H_SYNC_LEN;
                vblank_irq <= int'(v_next) == V_VIS && h_next == '0;
                // lines at or beyond V_TOTAL never equal v_next, so they never fire
                raster_irq <= int'(h_next) == H_IRQ && v_next == raster_line;
                if (int'(h_next) == H_SYNC_START)
                    vs <= int'(v_next) >= V_SYNC_START && int'(v_next) < V_SYNC_START + V_SYNC_LEN;
                // pending is read before this clk's raster_wr lands, so a colliding write waits a line
                if (h_next == '0)
                    raster_line <= pending;
            end
        end
    end

endmodule

// File: doc/irem_video_timing.md
Name: irem_video_timing

Overview:
- Generates the core raster: pixel enable, H/V counters, blanking, sync, plus vblank and raster-compare interrupt pulses.
- Drives core_ce_pix, core_hs, core_vs, core_hb and core_vb of the downstream video output stage (shrink, resync, mixer, rotate).
- Feeds hcnt/vcnt to the tilemap and sprite engines.
- Interrupt pulses feed the CPU interrupt controller.

Parameters:
- CE_DIV, 5, clk cycles per pixel; 40 MHz in gives 8 MHz pixel. Legal range 2..16.
- H_TOTAL, 512, pixel clocks per line.
- H_VIS, 320, visible pixels; active at hcnt 0..H_VIS-1.
- H_SYNC_START, 360, hcnt where hs asserts.
- H_SYNC_LEN, 32, hs width in pixels.
- V_TOTAL, 284, lines per frame.
- V_VIS, 240, visible lines; active at vcnt 0..V_VIS-1.
- V_SYNC_START, 256, vcnt where vs asserts.
- V_SYNC_LEN, 3, vs width in lines.
- H_IRQ, 328, hcnt at which the raster compare fires.

Ports:
- clk, in, 1, system/video clock.
- reset_n, in, 1, asynchronous active-low reset.
- raster_wr, in, 1, one-clk strobe: load raster_line_in into the pending compare register.
- raster_line_in, in, 9, requested interrupt line.
- ce_pix, out, 1, one-clk pixel enable every CE_DIV clocks.
- hcnt, out, 10, horizontal pixel counter.
- vcnt, out, 9, line counter.
- hb, out, 1, horizontal blank, active high.
- vb, out, 1, vertical blank, active high.
- hs, out, 1, horizontal sync, active high.
- vs, out, 1, vertical sync, active high.
- vblank_irq, out, 1, one-clk pulse at vblank start.
- raster_irq, out, 1, one-clk pulse on raster match.
- raster_line, out, 9, compare value currently in effect (readback).

Behaviour:
- Async reset (reset_n low) clears everything: div counter=0, hcnt=0, vcnt=0, ce_pix=0, hb=0, vb=0, hs=0, vs=0, both irqs=0, pending and active raster_line=9'h1FF.
- Reset deasserting mid-frame restarts the frame from 0,0; no partial-state carryover.
- Divider:
  - counts 0..CE_DIV-1 and wraps.
  - ce_pix is registered and high for exactly the clk where div==CE_DIV-1.
- Counters advance only on clks where ce_pix=1.
  - hcnt==H_TOTAL-1 wraps to 0.
  - vcnt advances on that same ce; vcnt==V_TOTAL-1 wraps to 0.
- hb, vb, hs, vs are registered decodes of the next counter values, so they align with hcnt/vcnt on the same clk (zero relative latency).
  - hb = hcnt>=H_VIS.
  - vb = vcnt>=V_VIS.
  - hs = H_SYNC_START <= hcnt < H_SYNC_START+H_SYNC_LEN.
  - vs changes only at hcnt==H_SYNC_START, keeping downstream resync edge-aligned; high for V_SYNC_LEN lines starting at V_SYNC_START.
- All outputs change only on ce clks, except irq pulses and readback.
- vblank_irq: high one clk, on the ce clk where vcnt becomes V_VIS and hcnt becomes 0.
- Raster compare (double-buffered):
  - raster_wr loads the pending register.
  - pending copies to active on the ce clk where hcnt becomes 0.
  - raster_irq is high one clk on the ce clk where hcnt becomes H_IRQ and vcnt==active.
- Raster boundary cases:
  - raster_wr on the same clk as the copy: the copy takes the old pending value; the new value takes effect next line.
  - active >= V_TOTAL (including reset value 1FF): never fires.
  - Back-to-back raster_wr: last write wins.
- Width rules:
  - Counter widths are fixed (10/9 bits); parameters must fit.
  - Compares are unsigned.
  - H_SYNC_START+H_SYNC_LEN must be <= H_TOTAL; no wrap support.
- Parameter legality is checked by elaboration-time assertions, not synthesized logic.

Decomposition:
- Package irem_video_pkg holds:
  - typedefs hcnt_t (logic[9:0]) and vcnt_t (logic[8:0]).
  - M92 default timing localparams, shared with tilemap/sprite blocks.
- One sub-module, irem_ce_div, owns the divider and produces ce_pix.
- Counter, decode and compare logic stay in the top.

Test Plan:
- Reset/divider: CE_DIV=5; release reset_n -> first ce_pix on clk 5; thereafter every 5 clks; all outputs 0 before the first ce.
- Line/frame: run one frame -> hcnt wraps 511->0; vcnt wraps 283->0; hb high for 192 pixels per line; vb high 44 lines; hs width 32 pixels; vs width 3 lines starting vcnt=256, edge exactly at hcnt=360.
- vblank_irq: full frame -> exactly one pulse per frame, one clk wide, coincident with vcnt=240, hcnt=0.
- Raster IRQ: write 100 during line 50 -> raster_irq at vcnt=100, hcnt=328 only; write 300 -> no pulse for a whole frame.
- Write/copy collision: raster_wr(20) on the clk hcnt becomes 0 on line 19 -> raster_line readback stays old on line 19, becomes 20 at line 20 start; pulse on line 20.
- Async reset mid-frame: assert reset_n low at vcnt=150 for 3 clks -> outputs clear immediately (no clock edge needed); restart from 0,0; raster_line=1FF.
